// File: rtl/fifo_read_serializer.sv
// Pops wide words from the fifo read port and streams each one out as RATIO narrow slices
// over a valid/ready interface. Back-to-back words are emitted without a gap cycle.
module fifo_read_serializer #(
  parameter int DATA_WIDTH  = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int MSB_FIRST   = 0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock_out,
  input  logic                   rst_out_n,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  input  logic                   fifo_valid,
  output logic                   fifo_ack,
  input  logic                   flush,
  output logic [OUT_WIDTH-1:0]   ser_data,
  output logic                   ser_valid,
  input  logic                   ser_ready,
  output logic                   ser_last,
  output logic [COUNT_WIDTH-1:0] word_count
);

  localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int IDX_W = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 r_state;
  logic [DATA_WIDTH-1:0]  r_word;
  logic [IDX_W-1:0]       r_idx;
  logic [OUT_WIDTH-1:0]   r_ser_data;
  logic                   r_ser_valid;
  logic                   r_ser_last;
  logic [COUNT_WIDTH-1:0] r_word_count;

  logic [OUT_WIDTH-1:0]   w_word_slice [RATIO];
  logic [OUT_WIDTH-1:0]   w_load_slice0;
  logic [IDX_W-1:0]       w_idx_inc;
  logic                   w_at_last;
  logic                   w_ack;

  // Slice order is fixed at elaboration; the held word is never shifted, only indexed.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    if (MSB_FIRST != 0) begin : g_msb
      assign w_word_slice[gi] = r_word[DATA_WIDTH-1-gi*OUT_WIDTH -: OUT_WIDTH];
    end else begin : g_lsb
      assign w_word_slice[gi] = r_word[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign w_load_slice0 = (MSB_FIRST != 0) ? fifo_data[DATA_WIDTH-1 -: OUT_WIDTH]
                                          : fifo_data[OUT_WIDTH-1:0];
  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_at_last = (r_idx == LAST_IDX);

  // Pop when idle, or when the final slice is leaving so the next word follows with no bubble.
  assign w_ack = rst_out_n & fifo_valid & ~flush &
                 ((r_state == IDLE) | ((r_state == SHIFT) & ser_ready & w_at_last));

  always_ff @(posedge clock_out or negedge rst_out_n) begin
    if (!rst_out_n) begin
      r_state      <= IDLE;
      r_word       <= '0;
      r_idx        <= '0;
      r_ser_data   <= '0;
      r_ser_valid  <= 1'b0;
      r_ser_last   <= 1'b0;
      r_word_count <= '0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ack) begin
            r_word      <= fifo_data;
            r_idx       <= '0;
            r_ser_data  <= w_load_slice0;
            r_ser_valid <= 1'b1;
            r_ser_last  <= 1'b0;
            r_state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            if (w_at_last) begin
              r_word_count <= r_word_count + COUNT_WIDTH'(1);
              if (w_ack) begin
                r_word      <= fifo_data;
                r_idx       <= '0;
                r_ser_data  <= w_load_slice0;
                r_ser_valid <= 1'b1;
                r_ser_last  <= 1'b0;
              end else begin
                r_state     <= IDLE;
                r_ser_valid <= 1'b0;
                r_ser_last  <= 1'b0;
              end
            end else begin
              r_idx      <= w_idx_inc;
              r_ser_data <= w_word_slice[w_idx_inc];
              r_ser_last <= (w_idx_inc == LAST_IDX);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fifo_ack   = w_ack;
  assign ser_data   = r_ser_data;
  assign ser_valid  = r_ser_valid;
  assign ser_last   = r_ser_last;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_fifo_read_serializer.sv
// Bench for fifo_read_serializer: an LSB-first instance and an MSB-first instance with a
// 4-bit word counter share one stimulus stream; a scoreboard checks every accepted slice.
module tb_fifo_read_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fifo_data;
  logic        fifo_valid;
  logic        flush;
  logic        ser_ready;
  logic        ack_a, ack_b;
  logic [7:0]  sd_a, sd_b;
  logic        sv_a, sv_b, sl_a, sl_b;
  logic [15:0] wc_a;
  logic [3:0]  wc_b;

  always #5 clk = ~clk;

  fifo_read_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0), .COUNT_WIDTH(16)) u_dut_a (
    .clock_out(clk), .rst_out_n(rst_n), .fifo_data(fifo_data), .fifo_valid(fifo_valid),
    .fifo_ack(ack_a), .flush(flush), .ser_data(sd_a), .ser_valid(sv_a),
    .ser_ready(ser_ready), .ser_last(sl_a), .word_count(wc_a)
  );

  fifo_read_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1), .COUNT_WIDTH(4)) u_dut_b (
    .clock_out(clk), .rst_out_n(rst_n), .fifo_data(fifo_data), .fifo_valid(fifo_valid),
    .fifo_ack(ack_b), .flush(flush), .ser_data(sd_b), .ser_valid(sv_b),
    .ser_ready(ser_ready), .ser_last(sl_b), .word_count(wc_b)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       first;
  } exp_t;

  // Expected slice sequences are packed with the first slice in the top byte.
  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_lsb;
    logic [31:0] exp_msb;
  } vec_t;

  exp_t        exp_a[$];
  exp_t        exp_b[$];
  exp_t        ea, eb;
  logic [31:0] src_q[$];
  vec_t        vecs[4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_wc = 0;
  int ack_cnt, valid_cnt, first_v, last_v;
  int ack_log[$];
  bit mon_en = 1'b0;
  bit drv_en = 1'b0;
  bit ack_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [31:0] w, input logic [31:0] lsb, input logic [31:0] msb);
    src_q.push_back(w);
    for (int k = 0; k < 4; k++) begin
      exp_a.push_back('{lsb[31-8*k -: 8], (k == 3), (k == 0)});
      exp_b.push_back('{msb[31-8*k -: 8], (k == 3), (k == 0)});
    end
    fifo_valid = 1'b1;
    fifo_data  = src_q[0];
  endtask

  task automatic push_rand();
    logic [31:0] w;
    w = $urandom;
    push_word(w, {w[7:0], w[15:8], w[23:16], w[31:24]}, w);
  endtask

  task automatic clr_stats();
    ack_cnt   = 0;
    valid_cnt = 0;
    first_v   = -1;
    last_v    = -1;
    ack_log.delete();
  endtask

  // Drop the unsent remainder of a word that a flush discards.
  task automatic drop_partial();
    while (exp_a.size() > 0 && !exp_a[0].first) begin
      void'(exp_a.pop_front());
      void'(exp_b.pop_front());
    end
  endtask

  task automatic drain(input int max_cyc, input bit rand_ready);
    int n;
    n = 0;
    while ((exp_a.size() > 0 || src_q.size() > 0 || sv_a) && n < max_cyc) begin
      if (rand_ready) ser_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    ser_ready = 1'b1;
    if (n >= max_cyc) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_a.size());
    end
  endtask

  task automatic wait_slice(input logic [7:0] d, input bit want_last, input string name);
    int n;
    n = 0;
    while (!(sv_a && sd_a == d && (!want_last || sl_a)) && n < 20) begin
      tick();
      n++;
    end
    chk(name, {24'd0, sd_a}, {24'd0, d});
  endtask

  always @(posedge clk) cyc++;

  // Bench fifo: the pop lands on the edge where the ack was seen.
  always @(posedge clk) begin
    #1;
    if (drv_en) begin
      if (ack_seen && src_q.size() > 0) void'(src_q.pop_front());
      fifo_valid = (src_q.size() > 0);
      fifo_data  = fifo_valid ? src_q[0] : 32'hDEAD_BEEF;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      ack_seen = ack_a;
      if (ack_a) begin
        ack_cnt++;
        ack_log.push_back(cyc);
      end
      if (sv_a) begin
        valid_cnt++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (sv_a && ser_ready && !flush) begin
        if (exp_a.size() == 0) begin
          chk("unexpected_slice", {24'd0, sd_a}, 32'hFFFF_FFFF);
        end else begin
          ea = exp_a.pop_front();
          eb = exp_b.pop_front();
          chk("a_data", {24'd0, sd_a}, {24'd0, ea.data});
          chk("a_last", {31'd0, sl_a}, {31'd0, ea.last});
          chk("b_valid", {31'd0, sv_b}, 32'd1);
          chk("b_data", {24'd0, sd_b}, {24'd0, eb.data});
          chk("b_last", {31'd0, sl_b}, {31'd0, eb.last});
          if (ea.last) exp_wc++;
          $display("slice cyc=%0d a=%h b=%h last=%0b wc_a=%0d", cyc, sd_a, sd_b, sl_a, wc_a);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'hA1B2_C3D4, 32'hD4C3_B2A1, 32'hA1B2_C3D4};
    vecs[1] = '{32'h1122_3344, 32'h4433_2211, 32'h1122_3344};
    vecs[2] = '{32'h0123_ABCD, 32'hCDAB_2301, 32'h0123_ABCD};
    vecs[3] = '{32'hFF00_807F, 32'h7F80_00FF, 32'hFF00_807F};

    // Reset held with the fifo offering a word.
    rst_n      = 1'b0;
    flush      = 1'b0;
    ser_ready  = 1'b1;
    fifo_valid = 1'b1;
    fifo_data  = 32'hA1B2_C3D4;
    repeat (3) tick();
    chk("rst_ack_a", {31'd0, ack_a}, 32'd0);
    chk("rst_ack_b", {31'd0, ack_b}, 32'd0);
    chk("rst_valid_a", {31'd0, sv_a}, 32'd0);
    chk("rst_valid_b", {31'd0, sv_b}, 32'd0);
    chk("rst_data_a", {24'd0, sd_a}, 32'd0);
    chk("rst_last_a", {31'd0, sl_a}, 32'd0);
    chk("rst_wc_a", {16'd0, wc_a}, 32'd0);
    chk("rst_wc_b", {28'd0, wc_b}, 32'd0);
    fifo_valid = 1'b0;
    drv_en = 1'b1;
    mon_en = 1'b1;
    rst_n  = 1'b1;
    tick();

    // Single word: four slices, one ack, slice 0 one cycle after the ack.
    clr_stats();
    push_word(vecs[0].word, vecs[0].exp_lsb, vecs[0].exp_msb);
    drain(50, 1'b0);
    chk("single_acks", ack_cnt, 1);
    chk("single_valid_cycles", valid_cnt, 4);
    chk("single_span", last_v - first_v, 3);
    if (ack_log.size() > 0) chk("single_latency", first_v - ack_log[0], 1);
    chk("single_wc", {16'd0, wc_a}, 32'd1);

    // Three words back to back with no gap.
    clr_stats();
    for (int i = 1; i < 4; i++) push_word(vecs[i].word, vecs[i].exp_lsb, vecs[i].exp_msb);
    drain(80, 1'b0);
    chk("b2b_acks", ack_cnt, 3);
    if (ack_log.size() == 3) begin
      chk("b2b_ack1_rel", ack_log[1] - ack_log[0], 4);
      chk("b2b_ack2_rel", ack_log[2] - ack_log[0], 8);
    end
    chk("b2b_valid_cycles", valid_cnt, 12);
    chk("b2b_span", last_v - first_v, 11);
    chk("b2b_wc_a", {16'd0, wc_a}, 32'd4);
    chk("b2b_wc_b", {28'd0, wc_b}, 32'd4);

    // Sink stalls for three cycles while C3 is presented; a next word is waiting.
    clr_stats();
    push_word(vecs[0].word, vecs[0].exp_lsb, vecs[0].exp_msb);
    wait_slice(8'hC3, 1'b0, "stall_reach_c3");
    ser_ready = 1'b0;
    push_word(vecs[1].word, vecs[1].exp_lsb, vecs[1].exp_msb);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data", {24'd0, sd_a}, 32'hC3);
      chk("stall_valid", {31'd0, sv_a}, 32'd1);
      chk("stall_no_ack", {31'd0, ack_a}, 32'd0);
    end
    chk("stall_ack_count", ack_cnt, 1);
    ser_ready = 1'b1;
    drain(60, 1'b0);
    chk("stall_wc", {16'd0, wc_a}, 32'd6);

    // Flush after D4 accepted; the waiting word must start cleanly at slice 44.
    push_word(vecs[0].word, vecs[0].exp_lsb, vecs[0].exp_msb);
    wait_slice(8'hC3, 1'b0, "flush_reach_c3");
    push_word(vecs[1].word, vecs[1].exp_lsb, vecs[1].exp_msb);
    flush = 1'b1;
    drop_partial();
    #1;
    chk("flush_no_ack", {31'd0, ack_a}, 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_valid_a", {31'd0, sv_a}, 32'd0);
    chk("flush_valid_b", {31'd0, sv_b}, 32'd0);
    chk("flush_wc", {16'd0, wc_a}, 32'd6);
    drain(60, 1'b0);
    chk("post_flush_wc", {16'd0, wc_a}, 32'd7);

    // Flush coinciding with the last-slice accept: the word is not counted.
    push_word(vecs[2].word, vecs[2].exp_lsb, vecs[2].exp_msb);
    wait_slice(8'h01, 1'b1, "flush_reach_last");
    flush = 1'b1;
    drop_partial();
    tick();
    flush = 1'b0;
    chk("flush_last_valid", {31'd0, sv_a}, 32'd0);
    chk("flush_last_wc", {16'd0, wc_a}, 32'd7);
    drain(20, 1'b0);

    // Vector table, one word at a time.
    for (int i = 0; i < 4; i++) begin
      push_word(vecs[i].word, vecs[i].exp_lsb, vecs[i].exp_msb);
      drain(50, 1'b0);
      chk("table_wc", {16'd0, wc_a}, 32'(exp_wc));
    end

    // Random words under random back-pressure; the 4-bit counter wraps past 15.
    for (int i = 0; i < 14; i++) push_rand();
    drain(600, 1'b1);
    chk("rand_wc_a", {16'd0, wc_a}, 32'd25);
    chk("rand_wc_b_wrap", {28'd0, wc_b}, 32'd9);

    // Asynchronous reset mid-word, applied away from the clock edge.
    push_word(vecs[3].word, vecs[3].exp_lsb, vecs[3].exp_msb);
    tick();
    tick();
    mon_en = 1'b0;
    drv_en = 1'b0;
    fifo_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, sv_a}, 32'd0);
    chk("async_rst_ack", {31'd0, ack_a}, 32'd0);
    chk("async_rst_wc_a", {16'd0, wc_a}, 32'd0);
    chk("async_rst_data", {24'd0, sd_a}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
